grf_dump: RTL and testbench
===========================

// Module: grf_dump
// PURPOSE
//  Read-side debug walker for the GRF. On a start pulse it steps a GRF read port through a
//  register range. Each register is emitted as an {index, value} record on a valid/ready stream.
//  It sits beside the GRF in the p4 datapath and drives a spare read address (A1/A2 mux, debug side).
//  Its consumer is a trace/UART sink or the testbench, complementing the write-side $display log.
// PARAMETERS
//  FIRST_REG  0   first register index visited (0..31)
//  LAST_REG   31  last register index visited (FIRST_REG..31)
//  SKIP_ZERO  0   1: registers reading 32'h0 are not emitted
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high
//  start      in   1   1-cycle request to begin a dump; ignored while busy
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   1-cycle pulse after the last record handshakes (or is skipped)
//  rd_addr    out  5   GRF read address
//  rd_data    in   32  GRF read data; combinational from rd_addr, same cycle
//  out_valid  out  1   record available
//  out_ready  in   1   consumer accepts the record when valid&ready at posedge
//  out_idx    out  5   register index of the record
//  out_data   out  32  register value of the record
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE. busy, done and out_valid are 0. rd_addr, out_idx and out_data are 0.
//    Reset mid-dump aborts immediately and no further records are produced.
//  - The FSM has states IDLE, READ, SEND and DONE. busy = (state != IDLE).
//  - IDLE: rd_addr=0. When start=1, set idx<=FIRST_REG and go to READ.
//  - READ: rd_addr=idx. Register out_idx<=idx and out_data<=rd_data at the posedge.
//    - If SKIP_ZERO and rd_data==0: if idx==LAST_REG go to DONE, else idx<=idx+1 and stay in READ.
//    - Otherwise go to SEND.
//  - SEND: out_valid=1, with out_idx and out_data held stable until the handshake.
//    - On valid&ready: if idx==LAST_REG go to DONE, else idx<=idx+1 and go to READ.
//    - With out_ready=0 the FSM stalls in SEND indefinitely.
//  - DONE: done=1 for exactly one cycle, then go to IDLE. A start in DONE is ignored.
//  - Latency: first out_valid is 2 cycles after the start edge. Every record costs at least 2 cycles.
//    With out_ready tied to 1 and the full range 0..31, done rises 65 cycles after start is sampled.
//  - Coherency: each value is sampled in its own READ cycle, so the dump is not an atomic snapshot.
//    A GRF write landing at the same posedge as the READ sample is not seen; the old value is emitted.
//  - $0 is emitted as 0 (GRF hardwires it). With SKIP_ZERO=1 it is always skipped.
//  - idx increments only by the FIRST_REG..LAST_REG rule. There is no wrap past 31.
//    FIRST_REG==LAST_REG produces exactly one record.
//  - start and out_ready are don't-care in states where they are not listed.
// CONFIGURATION
//  GRF_DUMP_DISPLAY_EN defined:
//    - On each accepted record, $display("dump $%d = %h", out_idx, out_data).
//    - On done, $display("dump end").
//  GRF_DUMP_DISPLAY_EN undefined: no simulation output. Ports and timing are identical.
// TESTING
//  1. Preload $0..$31 with i*0x11111111 and hold out_ready=1. Pulse start.
//     Expect 32 records idx 0..31 with matching values, out_valid on alternating cycles, done 65 cycles after start.
//  2. Preload $5=0xDEADBEEF. Hold out_ready=0 for 10 cycles during the record idx=5.
//     Expect out_valid held high with out_idx and out_data stable, then advance one cycle after ready rises.
//  3. SKIP_ZERO=1, with only $3=0x1 and $31=0xFFFFFFFF nonzero.
//     Expect exactly 2 records (3:0x1, 31:0xFFFFFFFF), then a done pulse.
//  4. Assert reset during SEND of idx=7.
//     Expect busy=0 and out_valid=0 on the next cycle, with no further records. A new start restarts from FIRST_REG.
//  5. Pulse start while busy, and again in DONE. Expect both ignored and the record count unchanged.
//  6. Write $9<=0xCAFE on the same posedge that READ samples idx=9.
//     Expect the old $9 value in the record; a second dump shows 0xCAFE.

Source files
------------

// File: rtl/grf_dump.sv
// rtl/grf_dump.sv - GRF read-side debug walker emitting {index, value} records on a valid/ready stream
// Optional GRF_DUMP_DISPLAY_EN: logs each accepted record and the end of the dump in simulation.
module grf_dump #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31,
   parameter bit          SKIP_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_idx,
   output logic [31:0] out_data
);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

   localparam logic [4:0] FIRST = 5'(FIRST_REG);
   localparam logic [4:0] LAST  = 5'(LAST_REG);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [4:0]  out_idx_q, out_idx_d;
   logic [31:0] out_data_q, out_data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        out_valid_q, out_valid_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      out_idx_d  = out_idx_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = FIRST;
               state_d = READ;
            end
         end
         READ: begin
            out_idx_d  = idx_q;
            out_data_d = rd_data;
            if (SKIP_ZERO && (rd_data == 32'h0)) begin
               if (idx_q == LAST) state_d = DONE;
               else               idx_d   = idx_q + 5'd1;
            end else begin
               state_d = SEND;
            end
         end
         SEND: begin
            // out_valid_q is high for the whole SEND state, so ready alone completes the handshake
            if (out_ready) begin
               if (idx_q == LAST) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = READ;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with the registered state
      rd_addr_d   = (state_d == READ) ? idx_d : 5'd0;
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
      out_valid_d = (state_d == SEND);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 5'd0;
         rd_addr_q   <= 5'd0;
         out_idx_q   <= 5'd0;
         out_data_q  <= 32'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rd_addr_q   <= rd_addr_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef GRF_DUMP_DISPLAY_EN
   always_ff @(posedge clk) begin
      if (!reset && out_valid_q && out_ready) $display("dump $%d = %h", out_idx_q, out_data_q);
      if (!reset && done_q) $display("dump end");
   end
`else
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_grf_dump.sv
// tb/tb_grf_dump.sv - scoreboard bench for grf_dump: full range, stall, skip-zero, reset abort, start filtering
// Two instances: dut0 with defaults, dut1 with SKIP_ZERO=1; each has its own GRF model.
module tb_grf_dump;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst0 = 1'b1, start0 = 1'b0, ready0 = 1'b1;
   logic        busy0, done0, valid0;
   logic [4:0]  rd_addr0, idx0;
   logic [31:0] rd_data0, data0;
   logic        rst1 = 1'b1, start1 = 1'b0, ready1 = 1'b1;
   logic        busy1, done1, valid1;
   logic [4:0]  rd_addr1, idx1;
   logic [31:0] rd_data1, data1;

   logic [31:0] rf0 [32];
   logic [31:0] rf1 [32];

   // GRF models: $0 hardwired to zero, combinational read
   assign rd_data0 = (rd_addr0 == 5'd0) ? 32'h0 : rf0[rd_addr0];
   assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : rf1[rd_addr1];

   // Write port; with wr_sync the write lands on the edge where dut0 reads wr_addr
   logic        wr_en = 1'b0, wr_tgt = 1'b0, wr_sync = 1'b0;
   logic [4:0]  wr_addr = 5'd0;
   logic [31:0] wr_data = 32'h0;
   always @(posedge clk) begin
      if (wr_en && (!wr_sync || rd_addr0 == wr_addr)) begin
         if (wr_tgt) rf1[wr_addr] <= wr_data;
         else        rf0[wr_addr] <= wr_data;
      end
   end

   grf_dump dut0 (
      .clk(clk), .reset(rst0), .start(start0), .busy(busy0), .done(done0),
      .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(valid0), .out_ready(ready0),
      .out_idx(idx0), .out_data(data0)
   );

   grf_dump #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1'b1)) dut1 (
      .clk(clk), .reset(rst1), .start(start1), .busy(busy1), .done(done1),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(valid1), .out_ready(ready1),
      .out_idx(idx1), .out_data(data1)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   rec_t q0[$];
   rec_t q1[$];
   int   rec0 = 0;
   int   rec1 = 0;
   logic stall0 = 1'b0;
   logic [4:0]  sidx0 = 5'd0;
   logic [31:0] sdat0 = 32'h0;

   // Monitor for dut0: pops on each handshake and checks hold-stability while stalled
   always @(negedge clk) begin
      if (stall0) begin
         chk("stall_valid_held", 32'(valid0), 32'h1);
         chk("stall_idx_stable", 32'(idx0), 32'(sidx0));
         chk("stall_data_stable", data0, sdat0);
      end
      stall0 <= valid0 && !ready0 && !rst0;
      sidx0  <= idx0;
      sdat0  <= data0;
      if (valid0 && ready0 && !rst0) begin
         chk("rec0_expected", 32'(q0.size() != 0), 32'h1);
         if (q0.size() != 0) begin
            chk("rec0_idx", 32'(idx0), 32'(q0[0].idx));
            chk("rec0_data", data0, q0[0].data);
            void'(q0.pop_front());
         end
         rec0 <= rec0 + 1;
      end
   end

   always @(negedge clk) begin
      if (valid1 && ready1 && !rst1) begin
         chk("rec1_expected", 32'(q1.size() != 0), 32'h1);
         if (q1.size() != 0) begin
            chk("rec1_idx", 32'(idx1), 32'(q1[0].idx));
            chk("rec1_data", data1, q1[0].data);
            void'(q1.pop_front());
         end
         rec1 <= rec1 + 1;
      end
   end

   task automatic wr(input logic tgt, input logic [4:0] a, input logic [31:0] d);
      wr_tgt  = tgt;
      wr_addr = a;
      wr_data = d;
      wr_sync = 1'b0;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic push0(input int i);
      q0.push_back('{idx: 5'(i), data: (i == 0) ? 32'h0 : rf0[i]});
   endtask

   // One dump on dut0; optionally stall at record stall_at or reset during record rst_at
   task automatic dump0(input int stall_at, input int rst_at);
      int  base;
      int  guard;
      bit  stalled;
      base    = rec0;
      stalled = 1'b0;
      for (int i = 0; i < 32; i++)
         if (rst_at < 0 || i < rst_at) push0(i);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      guard  = 0;
      while (!done0 && guard < 300) begin
         if (valid0 && stall_at >= 0 && int'(idx0) == stall_at && !stalled) begin
            ready0 = 1'b0;
            repeat (10) step();
            ready0 = 1'b1;
            step();
            chk("stall_advance_valid_low", 32'(valid0), 32'h0);
            stalled = 1'b1;
         end else if (valid0 && rst_at >= 0 && int'(idx0) == rst_at) begin
            ready0 = 1'b0;
            rst0   = 1'b1;
            step();
            rst0   = 1'b0;
            ready0 = 1'b1;
            chk("rst_busy", 32'(busy0), 32'h0);
            chk("rst_valid", 32'(valid0), 32'h0);
            chk("rst_out_idx", 32'(idx0), 32'h0);
            repeat (10) step();
            chk("rst_stays_idle", 32'(busy0), 32'h0);
            chk("rst_record_count", 32'(rec0 - base), 32'(rst_at));
            chk("rst_q0_drained", 32'(q0.size()), 32'h0);
            return;
         end else begin
            step();
            guard++;
         end
      end
      chk("dump0_done_seen", 32'(done0), 32'h1);
      step();
      chk("dump0_record_count", 32'(rec0 - base), 32'd32);
      chk("dump0_q_drained", 32'(q0.size()), 32'h0);
   endtask

   initial begin
      int c;
      int guard;
      int base;

      for (int i = 0; i < 32; i++) begin
         wr(1'b0, 5'(i), 32'(i) * 32'h1111_1111);
         wr(1'b1, 5'(i), 32'h0);
      end
      chk("reset_busy", 32'(busy0), 32'h0);
      chk("reset_done", 32'(done0), 32'h0);
      chk("reset_valid", 32'(valid0), 32'h0);
      chk("reset_rd_addr", 32'(rd_addr0), 32'h0);
      chk("reset_out_idx", 32'(idx0), 32'h0);
      chk("reset_out_data", data0, 32'h0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      step();

      // Full range with ready held; start retriggered while busy and in DONE
      base = rec0;
      for (int i = 0; i < 32; i++) push0(i);
      start0 = 1'b1;
      c = cyc;
      step();
      start0 = 1'b0;
      chk("busy_after_start", 32'(busy0), 32'h1);
      guard = 0;
      while (!valid0 && guard < 10) begin step(); guard++; end
      chk("first_valid_latency", 32'(cyc), 32'(c + 2));
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      guard = 0;
      while (!done0 && guard < 200) begin step(); guard++; end
      chk("done_latency", 32'(cyc), 32'(c + 65));
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      chk("done_one_cycle", 32'(done0), 32'h0);
      chk("start_in_done_ignored", 32'(busy0), 32'h0);
      repeat (5) step();
      chk("idle_after_ignored_starts", 32'(busy0), 32'h0);
      chk("full_record_count", 32'(rec0 - base), 32'd32);
      chk("full_q_drained", 32'(q0.size()), 32'h0);

      // Stall on record 5
      wr(1'b0, 5'd5, 32'hDEAD_BEEF);
      dump0(5, -1);

      // Write to $9 lands on the READ sample edge: old value first, then 0xCAFE
      wr_tgt  = 1'b0;
      wr_addr = 5'd9;
      wr_data = 32'h0000_CAFE;
      wr_sync = 1'b1;
      wr_en   = 1'b1;
      dump0(-1, -1);
      dump0(-1, -1);
      wr_en   = 1'b0;
      wr_sync = 1'b0;

      // Reset during SEND of record 7, then a clean restart from FIRST_REG
      dump0(-1, 7);
      dump0(-1, -1);

      // SKIP_ZERO instance: only $3 and $31 are nonzero
      wr(1'b1, 5'd3, 32'h0000_0001);
      wr(1'b1, 5'd31, 32'hFFFF_FFFF);
      q1.push_back('{idx: 5'd3, data: 32'h0000_0001});
      q1.push_back('{idx: 5'd31, data: 32'hFFFF_FFFF});
      base = rec1;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      guard = 0;
      while (!done1 && guard < 200) begin step(); guard++; end
      chk("skip_done_seen", 32'(done1), 32'h1);
      step();
      chk("skip_done_one_cycle", 32'(done1), 32'h0);
      chk("skip_record_count", 32'(rec1 - base), 32'd2);
      chk("skip_q_drained", 32'(q1.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
